// File: rtl/sram_like_arbiter.sv
// N-channel SRAM-like (req/addr_ok/data_ok) arbiter onto a single master port.
// Locks on the granted channel until addr_ok, and routes responses back in order through an index FIFO.
module sram_like_arbiter #(
    parameter int NUM_CH          = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RR              = 0
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_CH-1:0]          ch_req,
    input  logic [NUM_CH-1:0]          ch_wr,
    input  logic [2*NUM_CH-1:0]        ch_size,
    input  logic [DATA_W/8*NUM_CH-1:0] ch_wstrb,
    input  logic [ADDR_W*NUM_CH-1:0]   ch_addr,
    input  logic [DATA_W*NUM_CH-1:0]   ch_wdata,
    output logic [NUM_CH-1:0]          ch_addr_ok,
    output logic [NUM_CH-1:0]          ch_data_ok,
    output logic [DATA_W-1:0]          ch_rdata,
    output logic                       m_req,
    output logic                       m_wr,
    output logic [1:0]                 m_size,
    output logic [DATA_W/8-1:0]        m_wstrb,
    output logic [ADDR_W-1:0]          m_addr,
    output logic [DATA_W-1:0]          m_wdata,
    input  logic                       m_addr_ok,
    input  logic                       m_data_ok,
    input  logic [DATA_W-1:0]          m_rdata,
    output logic                       err_unexpected
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW = $clog2(MAX_OUTSTANDING);
    localparam int PW = AW + 1;
    localparam int SW = DATA_W / 8;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       gnt_q, rr_ptr_q, base, arb_idx, win, head;
    logic [2*NUM_CH-1:0] req_dbl;
    logic [NUM_CH-1:0]   req_rot;
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       fifo_q [MAX_OUTSTANDING];
    logic                fifo_full, fifo_empty, hs, pop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head       = fifo_q[rd_ptr_q[AW-1:0]];

    // Rotate the request vector so the search always starts at bit 0.
    assign base    = (RR != 0) ? rr_ptr_q : '0;
    assign req_dbl = {ch_req, ch_req};
    assign req_rot = req_dbl[base +: NUM_CH];

    always_comb begin
        int off;
        int sum;
        off = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) off = i;
        end
        sum = int'(base) + off;
        if (sum >= NUM_CH) sum = sum - NUM_CH;
        arb_idx = CW'(sum);
    end

    // m_req never depends on m_addr_ok; a lock entry already holds its FIFO slot.
    assign win   = (state_q == LOCKED) ? gnt_q : arb_idx;
    assign m_req = resetn && ((state_q == LOCKED) || (!fifo_full && (|ch_req)));
    assign hs    = m_req && m_addr_ok;
    assign pop   = resetn && m_data_ok && !fifo_empty;

    assign m_wr     = ch_wr[win];
    assign m_size   = ch_size[win*2 +: 2];
    assign m_wstrb  = ch_wstrb[win*SW +: SW];
    assign m_addr   = ch_addr[win*ADDR_W +: ADDR_W];
    assign m_wdata  = ch_wdata[win*DATA_W +: DATA_W];
    assign ch_rdata = m_rdata;

    always_comb begin
        ch_addr_ok = '0;
        ch_data_ok = '0;
        if (hs)  ch_addr_ok[win]  = 1'b1;
        if (pop) ch_data_ok[head] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (m_req && !m_addr_ok) state_d = LOCKED;
            LOCKED:  if (m_addr_ok)           state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            gnt_q          <= '0;
            rr_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            err_unexpected <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && m_req && !m_addr_ok) gnt_q <= arb_idx;
            if (RR != 0 && hs)
                rr_ptr_q <= (win == CW'(NUM_CH - 1)) ? '0 : win + 1'b1;
            if (hs)  wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (m_data_ok && fifo_empty) err_unexpected <= 1'b1;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (hs) fifo_q[wr_ptr_q[AW-1:0]] <= win;
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed plus random bench comparing fixed-priority and round-robin arbiters
// against a queue-based reference model of outstanding requests.
module tb_sram_like_arbiter;
    localparam int NCH  = 2;
    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  ch_req, ch_wr;
    logic [3:0]  ch_size;
    logic [7:0]  ch_wstrb;
    logic [63:0] ch_addr, ch_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;

    logic [1:0]  aok [2];
    logic [1:0]  dok [2];
    logic [31:0] rdat [2];
    logic        mreq [2];
    logic        mwr [2];
    logic [1:0]  msize [2];
    logic [3:0]  mstrb [2];
    logic [31:0] maddr [2];
    logic [31:0] mwdata [2];
    logic        err [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sram_like_arbiter #(.NUM_CH(NCH), .ADDR_W(32), .DATA_W(32),
                            .MAX_OUTSTANDING(MAXO), .RR(g)) u_dut (
            .clk(clk), .resetn(resetn),
            .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size), .ch_wstrb(ch_wstrb),
            .ch_addr(ch_addr), .ch_wdata(ch_wdata),
            .ch_addr_ok(aok[g]), .ch_data_ok(dok[g]), .ch_rdata(rdat[g]),
            .m_req(mreq[g]), .m_wr(mwr[g]), .m_size(msize[g]), .m_wstrb(mstrb[g]),
            .m_addr(maddr[g]), .m_wdata(mwdata[g]),
            .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
            .err_unexpected(err[g])
        );
    end

    // Reference model: per arbiter, a list of outstanding channel ids in issue order,
    // the channel currently waiting for addr_ok (-1 if none), the rotation start and error flag.
    int held [2];
    int ptr [2];
    int cnt [2];
    int mf [2][MAXO];
    bit merr [2];

    int n_cmp, n_bad;
    logic [1:0]  last_aok [2];
    logic [1:0]  last_dok [2];
    logic        last_mreq [2];
    logic [31:0] last_maddr [2];
    logic [31:0] last_rdata [2];
    logic        last_err [2];
    string       nm [2] = '{"fp", "rr"};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int m);
        int start;
        start = (m == 1) ? ptr[1] : 0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_req[(start + i) % NCH]) return (start + i) % NCH;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            held[m] = -1; ptr[m] = 0; cnt[m] = 0; merr[m] = 1'b0;
        end
    endtask

    task automatic tick();
        logic [1:0]  e_aok, e_dok;
        logic        e_req;
        int          w;
        logic [70:0] e_mf, o_mf;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            e_aok = '0; e_dok = '0; e_req = 1'b0; w = 0;
            if (!resetn) begin
                held[m] = -1; ptr[m] = 0; cnt[m] = 0; merr[m] = 1'b0;
            end else begin
                if (held[m] >= 0) begin
                    w = held[m]; e_req = 1'b1;
                end else if (cnt[m] < MAXO && ch_req != 2'b00) begin
                    w = pick(m); e_req = 1'b1;
                end
                if (e_req && m_addr_ok) e_aok[w] = 1'b1;
                if (m_data_ok && cnt[m] > 0) e_dok[mf[m][0]] = 1'b1;
            end
            chk($sformatf("%s_mreq", nm[m]), mreq[m], e_req);
            chk($sformatf("%s_addr_ok", nm[m]), aok[m], e_aok);
            chk($sformatf("%s_data_ok", nm[m]), dok[m], e_dok);
            chk($sformatf("%s_err", nm[m]), err[m], merr[m]);
            chk($sformatf("%s_rdata", nm[m]), rdat[m], m_rdata);
            if (e_req) begin
                e_mf = {ch_wr[w], ch_size[w*2 +: 2], ch_wstrb[w*4 +: 4],
                        ch_addr[w*32 +: 32], ch_wdata[w*32 +: 32]};
                o_mf = {mwr[m], msize[m], mstrb[m], maddr[m], mwdata[m]};
                chk($sformatf("%s_mfields", nm[m]), o_mf, e_mf);
            end
            last_aok[m] = aok[m]; last_dok[m] = dok[m]; last_mreq[m] = mreq[m];
            last_maddr[m] = maddr[m]; last_rdata[m] = rdat[m]; last_err[m] = err[m];
            if (resetn) begin
                if (m_data_ok) begin
                    if (cnt[m] > 0) begin
                        for (int j = 0; j < MAXO - 1; j++) mf[m][j] = mf[m][j+1];
                        cnt[m]--;
                    end else merr[m] = 1'b1;
                end
                if (e_req && m_addr_ok) begin
                    mf[m][cnt[m]] = w; cnt[m]++; held[m] = -1;
                    if (m == 1) ptr[m] = (w + 1) % NCH;
                end else if (e_req) held[m] = w;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic wr, input logic [1:0] sz,
                          input logic [3:0] st, input logic [31:0] a, input logic [31:0] d);
        ch_wr[c] = wr; ch_size[c*2 +: 2] = sz; ch_wstrb[c*4 +: 4] = st;
        ch_addr[c*32 +: 32] = a; ch_wdata[c*32 +: 32] = d;
    endtask

    initial begin
        logic [1:0] rr_seen [4];
        logic [31:0] lock_addr [3];
        n_cmp = 0; n_bad = 0;
        model_reset();
        ch_req = '0; ch_wr = '0; ch_size = '0; ch_wstrb = '0; ch_addr = '0; ch_wdata = '0;
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0; resetn = 1'b0;

        // Reset: outputs quiet even with requests and handshakes pending
        set_ch(0, 1'b0, 2'd2, 4'hf, 32'h1000, 32'h0);
        set_ch(1, 1'b0, 2'd2, 4'hf, 32'h2000, 32'h0);
        ch_req = 2'b11; m_addr_ok = 1'b1;
        tick(); tick();
        chk("rst_mreq", last_mreq[0], 1'b0);
        chk("rst_aok", last_aok[1], 2'b00);
        chk("rst_err", last_err[0], 1'b0);
        ch_req = '0; m_addr_ok = 1'b0; resetn = 1'b1;
        tick();

        // Single read
        ch_req = 2'b01; m_addr_ok = 1'b1;
        tick();
        chk("single_aok", last_aok[0], 2'b01);
        ch_req = '0; m_addr_ok = 1'b0;
        tick();
        m_data_ok = 1'b1; m_rdata = 32'hDEADBEEF;
        tick();
        chk("single_dok", last_dok[0], 2'b01);
        chk("single_rdata", last_rdata[0], 32'hDEADBEEF);
        m_data_ok = 1'b0;
        tick();

        // Simultaneous requests, fixed priority
        ch_req = 2'b11; m_addr_ok = 1'b1;
        tick();
        chk("fp_first", last_aok[0], 2'b01);
        ch_req = 2'b10;
        tick();
        chk("fp_second", last_aok[0], 2'b10);
        ch_req = '0; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h1111_2222;
        tick();
        chk("fp_resp0", last_dok[0], 2'b01);
        tick();
        chk("fp_resp1", last_dok[0], 2'b10);
        m_data_ok = 1'b0;

        // Round robin from a fresh pointer
        resetn = 1'b0; tick(); resetn = 1'b1;
        ch_req = 2'b11; m_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            rr_seen[i] = last_aok[1];
        end
        chk("rr_g0", rr_seen[0], 2'b01);
        chk("rr_g1", rr_seen[1], 2'b10);
        chk("rr_g2", rr_seen[2], 2'b01);
        chk("rr_g3", rr_seen[3], 2'b10);
        ch_req = '0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        m_data_ok = 1'b0;

        // Lock: ch1 waits, ch0 shows up late but must not steal the port
        set_ch(1, 1'b1, 2'd1, 4'h3, 32'h2468, 32'hCAFE_F00D);
        ch_req = 2'b10;
        tick(); lock_addr[0] = last_maddr[0];
        ch_req = 2'b11;
        tick(); lock_addr[1] = last_maddr[0];
        tick(); lock_addr[2] = last_maddr[0];
        for (int i = 0; i < 3; i++) chk($sformatf("lock_addr%0d", i), lock_addr[i], 32'h2468);
        m_addr_ok = 1'b1;
        tick();
        chk("lock_ch1", last_aok[0], 2'b10);
        ch_req = 2'b01;
        tick();
        chk("lock_ch0", last_aok[0], 2'b01);
        ch_req = '0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
        tick(); tick();
        m_data_ok = 1'b0;

        // Full FIFO: a pop in the same cycle does not free the push slot
        ch_req = 2'b01; m_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        tick();
        chk("full_block", last_mreq[0], 1'b0);
        m_data_ok = 1'b1;
        tick();
        chk("full_pop_block", last_mreq[0], 1'b0);
        chk("full_pop_dok", last_dok[0], 2'b01);
        m_data_ok = 1'b0;
        tick();
        chk("full_resume", last_aok[0], 2'b01);
        ch_req = '0; m_addr_ok = 1'b0; m_data_ok = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Unexpected response
        tick();
        chk("unexp_dok", last_dok[0], 2'b00);
        m_data_ok = 1'b0;
        tick();
        chk("unexp_err", last_err[0], 1'b1);
        tick();
        chk("unexp_sticky", last_err[1], 1'b1);
        resetn = 1'b0;
        tick();
        chk("unexp_clear", last_err[0], 1'b0);
        resetn = 1'b1;
        tick();

        // Random traffic with occasional mid-stream resets
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if (held[0] != c && held[1] != c) begin
                    ch_req[c] = ($urandom_range(0, 9) < 6);
                    set_ch(c, 1'($urandom), 2'($urandom_range(0, 2)), 4'($urandom),
                           $urandom, $urandom);
                end
            end
            m_addr_ok = ($urandom_range(0, 9) < 7);
            m_data_ok = ($urandom_range(0, 9) < 5);
            m_rdata   = $urandom;
            resetn    = ($urandom_range(0, 149) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
